// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: generic valid/ready pipeline stage register for the RV32I core.
// Carries an arbitrary packed payload, supports stall (hold) and flush (bubble
// insertion), and optionally a second skid entry so in_ready_o is registered.
module pipe_stage_hs #(
   parameter int                DATA_W     = 32,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(32'h00000013),
   parameter bit                SKID       = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occ_o
);

   // The state value doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready;
   logic              out_valid;
   logic              acc;
   logic              drn;

   // Handshake decode: hold masks both sides; with a skid entry ready is
   // independent of out_ready_i so no combinational ready chain forms.
   always_comb begin
      out_valid = (state_q != EMPTY) & ~hold_i;
      if (SKID) begin
         in_ready = (state_q != FULL) & ~hold_i & ~rst;
      end else begin
         in_ready = ((state_q == EMPTY) | out_ready_i) & ~hold_i & ~rst;
      end
      acc = in_valid_i & in_ready;
      drn = out_valid & out_ready_i;
   end

   // Next-state and payload movement; flush wins over everything, a
   // same-cycle drain has already been sampled downstream.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = EMPTY;
         main_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end else begin
         case (state_q)
            EMPTY: begin
               if (acc) begin
                  state_d = ONE;
                  main_d  = in_data_i;
               end
            end
            ONE: begin
               if (acc && drn) begin
                  main_d = in_data_i;
               end else if (acc && SKID) begin
                  state_d = FULL;
                  skid_d  = in_data_i;
               end else if (drn) begin
                  state_d = EMPTY;
                  main_d  = BUBBLE_VAL;
               end
            end
            FULL: begin
               if (drn) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = BUBBLE_VAL;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = BUBBLE_VAL;
               skid_d  = BUBBLE_VAL;
            end
         endcase
      end
   end

   // State and main payload register; reset loads the bubble so no bit is X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end

   generate
      if (SKID) begin : g_skid
         // Second entry absorbing one beat of backpressure.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_q <= BUBBLE_VAL;
            end else begin
               skid_q <= skid_d;
            end
         end
      end else begin : g_no_skid
         assign skid_q = BUBBLE_VAL;
      end
   endgenerate

   assign in_ready_o  = in_ready;
   assign out_valid_o = out_valid;
   assign out_data_o  = main_q;
   assign occ_o       = state_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: scoreboard bench driving a SKID=1 and a SKID=0 instance with
// shared stimulus; each is checked against a bounded-FIFO reference model.
module tb_pipe_stage_hs;

   localparam int          DATA_W = 32;
   localparam logic [31:0] BUB    = 32'h00000013;

   logic              clk = 1'b0;
   logic              rst;
   logic              hold_i, flush_i, in_valid_i, out_ready_i;
   logic [DATA_W-1:0] in_data_i;

   logic              rdy_s, vld_s, rdy_n, vld_n;
   logic [DATA_W-1:0] dat_s, dat_n;
   logic [1:0]        occ_s, occ_n;

   int total = 0;
   int bad   = 0;

   // reference model: number of held items and their contents in FIFO order
   int          cnt_s = 0, cnt_n = 0;
   logic [31:0] sb_s[$];
   logic [31:0] sb_n[$];
   bit          mon_en = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_hs #(.DATA_W(DATA_W), .BUBBLE_VAL(BUB), .SKID(1'b1)) u_skid (
      .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(rdy_s), .in_data_i(in_data_i),
      .out_valid_o(vld_s), .out_ready_i(out_ready_i), .out_data_o(dat_s),
      .occ_o(occ_s));

   pipe_stage_hs #(.DATA_W(DATA_W), .BUBBLE_VAL(BUB), .SKID(1'b0)) u_noskid (
      .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(rdy_n), .in_data_i(in_data_i),
      .out_valid_o(vld_n), .out_ready_i(out_ready_i), .out_data_o(dat_n),
      .occ_o(occ_n));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // capacity 2 with skid, otherwise 1 unless the head leaves this cycle
   function automatic logic exp_ready(input bit skid, input int cnt);
      if (rst || hold_i) return 1'b0;
      if (skid) return (cnt < 2);
      return (cnt == 0) || out_ready_i;
   endfunction

   function automatic logic exp_valid(input int cnt);
      return (cnt > 0) && !hold_i;
   endfunction

   task automatic mon_one(input bit skid, input string p, input int cnt, input logic rdy,
                          input logic vld, input logic [31:0] dat, input logic [1:0] occ);
      bit          have;
      logic [31:0] head;
      check({p, "_in_ready"}, 32'(rdy), 32'(exp_ready(skid, cnt)));
      check({p, "_out_valid"}, 32'(vld), 32'(exp_valid(cnt)));
      check({p, "_occ"}, 32'(occ), 32'(cnt));
      have = skid ? (sb_s.size() != 0) : (sb_n.size() != 0);
      head = BUB;
      if (have) head = skid ? sb_s[0] : sb_n[0];
      if (cnt != 0) begin
         if (!have) begin
            total++;
            bad++;
            $display("FAIL %s_scoreboard: got empty queue expected an entry at %0t", p, $time);
         end else begin
            check({p, "_data"}, dat, head);
            if (exp_valid(cnt) && out_ready_i) begin
               if (skid) void'(sb_s.pop_front());
               else void'(sb_n.pop_front());
            end
         end
      end else begin
         check({p, "_bubble"}, dat, BUB);
      end
   endtask

   // Monitor: mid-cycle, inputs and combinational outputs are settled.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_one(1'b1, "skid", cnt_s, rdy_s, vld_s, dat_s, occ_s);
         mon_one(1'b0, "noskid", cnt_n, rdy_n, vld_n, dat_n, occ_n);
      end
   end

   // Advance one clock from the current inputs and update the model.
   task automatic cycle();
      bit acc_s, drn_s, acc_n, drn_n;
      @(negedge clk);
      #2;
      acc_s = in_valid_i && exp_ready(1'b1, cnt_s);
      drn_s = exp_valid(cnt_s) && out_ready_i;
      acc_n = in_valid_i && exp_ready(1'b0, cnt_n);
      drn_n = exp_valid(cnt_n) && out_ready_i;
      @(posedge clk);
      #1;
      if (flush_i) begin
         cnt_s = 0; sb_s.delete();
         cnt_n = 0; sb_n.delete();
      end else begin
         if (acc_s) sb_s.push_back(in_data_i);
         if (acc_n) sb_n.push_back(in_data_i);
         cnt_s = cnt_s + int'(acc_s) - int'(drn_s);
         cnt_n = cnt_n + int'(acc_n) - int'(drn_n);
      end
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic r,
                       input logic h, input logic f);
      in_valid_i  = v;
      in_data_i   = d;
      out_ready_i = r;
      hold_i      = h;
      flush_i     = f;
      cycle();
   endtask

   task automatic check_reset_outputs(input string p);
      check({p, "_skid_occ"}, 32'(occ_s), 32'd0);
      check({p, "_skid_valid"}, 32'(vld_s), 32'd0);
      check({p, "_skid_ready"}, 32'(rdy_s), 32'd0);
      check({p, "_skid_data"}, dat_s, BUB);
      check({p, "_noskid_occ"}, 32'(occ_n), 32'd0);
      check({p, "_noskid_valid"}, 32'(vld_n), 32'd0);
      check({p, "_noskid_ready"}, 32'(rdy_n), 32'd0);
      check({p, "_noskid_data"}, dat_n, BUB);
   endtask

   initial begin
      rst = 1'b1;
      hold_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      in_data_i = '0;
      #3;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // streaming with constant downstream ready
      step(1, 32'h11, 1, 0, 0);
      step(1, 32'h22, 1, 0, 0);
      step(1, 32'h33, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);

      // backpressure fills the skid entry, then drains in order
      step(1, 32'hA1, 1, 0, 0);
      step(1, 32'hA2, 0, 0, 0);
      step(0, 32'h0, 0, 0, 0);
      step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);

      // flush while full with a same-cycle input: that input is dropped
      step(1, 32'hB1, 0, 0, 0);
      step(1, 32'hB2, 0, 0, 0);
      step(1, 32'hB3, 0, 0, 1);
      step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);

      // hold freezes contents and masks valid, then the item leaves once
      step(1, 32'hC1, 0, 0, 0);
      step(1, 32'hC9, 1, 1, 0);
      step(1, 32'hC9, 1, 1, 0);
      step(1, 32'hC9, 1, 1, 0);
      step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);

      // without skid, ready follows out_ready_i within the cycle
      step(1, 32'hD1, 1, 0, 0);
      in_valid_i = 1'b1; in_data_i = 32'hD2; hold_i = 1'b0; flush_i = 1'b0;
      out_ready_i = 1'b0;
      #1;
      check("comb_ready_low", 32'(rdy_n), 32'd0);
      out_ready_i = 1'b1;
      #1;
      check("comb_ready_high", 32'(rdy_n), 32'd1);
      cycle();
      step(1, 32'hD3, 0, 0, 0);
      step(1, 32'hD3, 1, 0, 0);
      step(0, 32'h0, 0, 0, 0);
      step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
              $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      end
      for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 0);

      // asynchronous reset mid-cycle while full
      step(1, 32'hE1, 0, 0, 0);
      step(1, 32'hE2, 0, 0, 0);
      in_valid_i = 1'b0; out_ready_i = 1'b0;
      mon_en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      cnt_s = 0; sb_s.delete();
      cnt_n = 0; sb_n.delete();
      mon_en = 1'b1;
      step(1, 32'hF1, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
